// File: rtl/scara_cmd_pkg.sv
// scara_cmd_pkg: command word layout, command codes and fetcher states shared by producer and consumer
package scara_cmd_pkg;
  localparam int CMD_W = 4;
  localparam int COORD_W = 14;
  localparam int CMD_WORD_W = 32;
  localparam int CMD_LSB = 28;
  localparam int X_LSB = 14;
  localparam int Y_LSB = 0;
  typedef enum logic [CMD_W-1:0] {G00, G01, G20, G21, G90, G91, M2, M6, M72} cmd_code_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, ISSUE, HOLDOFF, DONE} fetch_state_t;
endpackage

// File: rtl/cmd_word_unpack.sv
// cmd_word_unpack: slices a packed command word and flags program end and illegal codes
module cmd_word_unpack
  import scara_cmd_pkg::*;
(
  input  logic [CMD_WORD_W-1:0] word,
  output logic [CMD_W-1:0]      cmd,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic                  is_m2,
  output logic                  illegal
);
  assign cmd = word[CMD_LSB +: CMD_W];
  assign x = word[X_LSB +: COORD_W];
  assign y = word[Y_LSB +: COORD_W];
  assign is_m2 = cmd == M2;
  assign illegal = cmd > M72;
endmodule

// File: rtl/gcode_command_fetcher.sv
// gcode_command_fetcher: walks the program RAM and presents one unpacked command per memory_ready strobe
module gcode_command_fetcher
  import scara_cmd_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int HOLDOFF_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  block,
  input  logic                  controller_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic [CMD_WORD_W-1:0] mem_rdata,
  output logic [CMD_W-1:0]      cmd,
  output logic [COORD_W-1:0]    x_value_in,
  output logic [COORD_W-1:0]    y_value_in,
  output logic                  memory_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CNT_W = $clog2(HOLDOFF_CYC);
  fetch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [CMD_W-1:0] cmd_n, u_cmd;
  logic [COORD_W-1:0] x_n, y_n, u_x, u_y;
  logic rd_n, rdy_n, done_n, err_n, busy_n, u_m2, u_bad;
  cmd_word_unpack u_unpack (
    .word(mem_rdata),
    .cmd(u_cmd),
    .x(u_x),
    .y(u_y),
    .is_m2(u_m2),
    .illegal(u_bad)
  );
  // A blocked FETCH drops mem_rd; re-entering with mem_rd low reissues the read before moving on.
  always_comb begin
    state_n = state;
    addr_n = mem_addr;
    rd_n = 1'b0;
    rdy_n = 1'b0;
    cnt_n = cnt;
    cmd_n = cmd;
    x_n = x_value_in;
    y_n = y_value_in;
    done_n = done;
    err_n = error;
    if (!block)
      case (state)
        IDLE, DONE: if (start) begin
          state_n = FETCH;
          addr_n = '0;
          rd_n = 1'b1;
          done_n = 1'b0;
          err_n = 1'b0;
        end
        FETCH: begin
          state_n = mem_rd ? WAIT_RD : FETCH;
          rd_n = !mem_rd;
        end
        WAIT_RD: begin
          cmd_n = u_cmd;
          x_n = u_x;
          y_n = u_y;
          state_n = (u_m2 || u_bad) ? DONE : ISSUE;
          done_n = u_m2 || u_bad;
          err_n = u_bad;
        end
        ISSUE: if (controller_ready) begin
          state_n = HOLDOFF;
          rdy_n = 1'b1;
          cnt_n = '0;
        end
        HOLDOFF:
          if (cnt != CNT_W'(HOLDOFF_CYC - 1)) cnt_n = cnt + 1'b1;
          else if (&mem_addr) begin
            state_n = DONE;
            done_n = 1'b1;
            err_n = 1'b1;
          end else begin
            state_n = FETCH;
            addr_n = mem_addr + 1'b1;
            rd_n = 1'b1;
          end
        default: state_n = IDLE;
      endcase
  end
  assign busy_n = !(state_n == IDLE || state_n == DONE);
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      cmd <= '0;
      x_value_in <= '0;
      y_value_in <= '0;
      memory_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_addr <= addr_n;
      mem_rd <= rd_n;
      cmd <= cmd_n;
      x_value_in <= x_n;
      y_value_in <= y_n;
      memory_ready <= rdy_n;
      busy <= busy_n;
      done <= done_n;
      error <= err_n;
    end
endmodule

// File: tb/tb_gcode_command_fetcher.sv
// tb_gcode_command_fetcher: random and directed programs checked against an expected-command queue
module tb_gcode_command_fetcher;
  localparam int H = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, start, block, controller_ready;
  logic [9:0] mem_addr;
  logic mem_rd, memory_ready, busy, done, error;
  logic [31:0] mem_rdata;
  logic [3:0] cmd;
  logic [13:0] x_value_in, y_value_in;
  logic start3, block3, ready3;
  logic [2:0] mem_addr3;
  logic mem_rd3, mr3, busy3, done3, err3;
  logic [31:0] mem_rdata3;
  logic [3:0] cmd3;
  logic [13:0] x3, y3;
  logic [31:0] mem [1024];
  logic [31:0] mem3 [8];
  gcode_command_fetcher #(.ADDR_W(10), .HOLDOFF_CYC(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .block(block),
    .controller_ready(controller_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .cmd(cmd), .x_value_in(x_value_in), .y_value_in(y_value_in),
    .memory_ready(memory_ready), .busy(busy), .done(done), .error(error)
  );
  gcode_command_fetcher #(.ADDR_W(3), .HOLDOFF_CYC(H)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .block(block3),
    .controller_ready(ready3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .mem_rdata(mem_rdata3), .cmd(cmd3), .x_value_in(x3), .y_value_in(y3),
    .memory_ready(mr3), .busy(busy3), .done(done3), .error(err3)
  );
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (mem_rd3) mem_rdata3 <= mem3[mem_addr3];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask
  int cyc = 0, k3 = 0, t_start;
  logic [31:0] exp_q [$];
  int st_q [$];
  logic [31:0] mw;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset_n && memory_ready) begin
      st_q.push_back(cyc);
      chk("strobe_cond", {controller_ready, block}, 2'b10);
      chk("strobe_extra", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mw = exp_q.pop_front();
        chk("cmd", cmd, mw[31:28]);
        chk("x", x_value_in, mw[27:14]);
        chk("y", y_value_in, mw[13:0]);
      end
    end
    if (reset_n && mr3) begin
      chk("strobe3_extra", k3 < 8, 1);
      if (k3 < 8) begin
        chk("cmd3", cmd3, mem3[k3][31:28]);
        chk("x3", x3, mem3[k3][27:14]);
        chk("y3", y3, mem3[k3][13:0]);
      end
      k3++;
    end
  end
  function automatic logic [31:0] rnd_cmd();
    logic [3:0] c;
    c = 4'($urandom_range(0, 7));
    if (c >= 4'd6) c = c + 4'd1;
    return {c, 14'($urandom), 14'($urandom)};
  endfunction
  task automatic push_word(input int a, input logic [31:0] w);
    mem[a] = w;
    exp_q.push_back(w);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    block = 1'b0;
    start = 1'b1;
    t_start = cyc;
    st_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (rnd) begin
        controller_ready = 1'($urandom);
        block = $urandom_range(0, 3) == 0;
      end
    end
    chk("done_timeout", done, 1);
    block = 1'b0;
    controller_ready = 1'b1;
  endtask
  task automatic wait_sig(input string tag, input bit rd);
    int n = 0;
    while (!(rd ? mem_rd : memory_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rd ? mem_rd : memory_ready, 1);
  endtask
  task automatic chk_reset_vals();
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_x", x_value_in, 0);
    chk("rst_y", y_value_in, 0);
    chk("rst_ready", memory_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
  endtask
  task automatic block_window(input string tag);
    logic [9:0] a0 = mem_addr;
    block = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk({tag, "_rd"}, mem_rd, 0);
      chk({tag, "_ready"}, memory_ready, 0);
      chk({tag, "_addr"}, mem_addr, a0);
    end
    block = 1'b0;
  endtask
  initial begin
    int s, f, tc, n;
    logic [31:0] w0;
    bit term_err;
    reset_n = 1'b0; start = 1'b0; block = 1'b0; controller_ready = 1'b1;
    start3 = 1'b0; block3 = 1'b0; ready3 = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    // basic program: latency, throughput, done without error
    push_word(0, {4'd2, 28'd0});
    push_word(1, {4'd1, 14'd100, 14'd200});
    mem[2] = {4'd6, 28'd0};
    pulse_start();
    wait_done(0);
    chk("basic_error", error, 0);
    chk("basic_busy", busy, 0);
    chk("basic_strobes", st_q.size(), 2);
    if (st_q.size() == 2) begin
      chk("latency", st_q[0] - t_start, 4);
      chk("throughput", st_q[1] - st_q[0], H + 3);
    end
    // back-pressure held in ISSUE
    w0 = rnd_cmd();
    push_word(0, w0);
    push_word(1, rnd_cmd());
    mem[2] = {4'd6, 28'd0};
    controller_ready = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("bp_ready", memory_ready, 0);
      chk("bp_cmd", cmd, w0[31:28]);
      chk("bp_x", x_value_in, w0[27:14]);
      chk("bp_y", y_value_in, w0[13:0]);
    end
    controller_ready = 1'b1;
    tc = cyc;
    wait_done(0);
    chk("bp_release", st_q.size() > 0 ? st_q[0] - tc : -1, 1);
    chk("bp_left", exp_q.size(), 0);
    // block during HOLDOFF, then during FETCH
    for (int i = 0; i < 4; i++) push_word(i, rnd_cmd());
    mem[4] = {4'd6, 28'd0};
    pulse_start();
    wait_sig("blk_strobe_wait", 0);
    s = cyc;
    block_window("blk_hold");
    wait_sig("blk_fetch_wait", 1);
    f = cyc;
    block_window("blk_fetch");
    wait_done(0);
    chk("blk_left", exp_q.size(), 0);
    chk("blk_strobes", st_q.size(), 4);
    if (st_q.size() == 4) begin
      chk("hold_freeze", f - s, H + 10);
      chk("fetch_freeze", st_q[1] - f, 14);
    end
    // edge spacing with three M72
    for (int i = 0; i < 3; i++) push_word(i, {4'd8, 14'($urandom), 14'($urandom)});
    mem[3] = {4'd6, 28'd0};
    pulse_start();
    wait_done(0);
    chk("m72_strobes", st_q.size(), 3);
    for (int i = 1; i < st_q.size(); i++) begin
      chk("m72_low_gap", st_q[i] - st_q[i-1] - 1 >= H, 1);
      chk("m72_period", st_q[i] - st_q[i-1], H + 3);
    end
    // illegal code
    mem[0] = {4'd12, 28'($urandom)};
    pulse_start();
    wait_done(0);
    chk("ill_error", error, 1);
    chk("ill_strobes", st_q.size(), 0);
    chk("ill_cmd", cmd, 12);
    // restart from DONE clears done/error and begins at address 0
    push_word(0, rnd_cmd());
    mem[1] = {4'd6, 28'd0};
    pulse_start();
    chk("rs_done", done, 0);
    chk("rs_error", error, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_busy", busy, 1);
    wait_done(0);
    chk("rs_err_end", error, 0);
    chk("rs_left", exp_q.size(), 0);
    // address overrun on the 3-bit instance
    for (int i = 0; i < 8; i++) mem3[i] = rnd_cmd();
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_done", done3, 1);
    chk("ovr_error", err3, 1);
    chk("ovr_addr", mem_addr3, 7);
    chk("ovr_strobes", k3, 8);
    // reset during a strobe
    push_word(0, rnd_cmd());
    push_word(1, rnd_cmd());
    mem[2] = {4'd6, 28'd0};
    pulse_start();
    wait_sig("rst_strobe_wait", 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    exp_q.delete();
    // random programs under random back-pressure and block
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_word(i, rnd_cmd());
      term_err = 1'($urandom);
      mem[n] = term_err ? {4'($urandom_range(9, 15)), 28'($urandom)} : {4'd6, 28'($urandom)};
      pulse_start();
      wait_done(1);
      chk("rnd_error", error, term_err);
      chk("rnd_left", exp_q.size(), 0);
      chk("rnd_addr", mem_addr, n);
      chk("rnd_busy", busy, 0);
      exp_q.delete();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gcode_command_fetcher.md
# gcode_command_fetcher

Producer side of the controller command handshake. Walks a program of packed G-code command words in a synchronous-read program memory, unpacks each word into `cmd`/`x_value_in`/`y_value_in`, and presents one command at a time with a single-cycle `memory_ready` strobe, paced by `controller_ready` and `block`. Sits between the program RAM (written by the host loader) and the controller command interface.

## Interface

Parameters:
- `ADDR_W`: default 10. Program memory address width.
- `HOLDOFF_CYC`: default 4, minimum 2. Cycles that `memory_ready` stays low after each strobe.

Ports:
- `clk`: input, 1. System clock.
- `reset_n`: input, 1. Synchronous, active-low reset.
- `start`: input, 1. Begin the program at address 0. Sampled in IDLE and DONE only.
- `block`: input, 1. Freeze. No strobe and no state advance while high.
- `controller_ready`: input, 1. The consumer accepts a command.
- `mem_addr`: output, ADDR_W. Program memory read address.
- `mem_rd`: output, 1. Read enable. Data is valid exactly 1 cycle later.
- `mem_rdata`: input, 32. Word format: [31:28] cmd, [27:14] x, [13:0] y.
- `cmd`: output, 4. Command code.
- `x_value_in`: output, 14. X field.
- `y_value_in`: output, 14. Y field.
- `memory_ready`: output, 1. Command-valid strobe.
- `busy`: output, 1. High in any state except IDLE and DONE.
- `done`: output, 1. Program finished.
- `error`: output, 1. Illegal code or address overrun.

## Operation

- Command codes, in this order: G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8. Codes 9–15 are illegal.
- **IDLE** → FETCH on `start`. On that transition: address ← 0, `done` ← 0, `error` ← 0.
- **FETCH**: `mem_rd`=1 for one cycle at the current address → WAIT_RD.
- **WAIT_RD**: register the `mem_rdata` fields into `cmd`/`x_value_in`/`y_value_in`, then:
  - code M2: → DONE, `done`=1, no strobe. M2 is never presented to the consumer.
  - illegal code: → DONE, `done`=1, `error`=1.
  - otherwise: → ISSUE.
- **ISSUE**: wait until `controller_ready`=1 and `block`=0 in the same cycle. Then drive `memory_ready`=1 for exactly that one cycle → HOLDOFF.
- **HOLDOFF**: count HOLDOFF_CYC cycles with `memory_ready`=0.
  - The gap guarantees a fresh rising edge per command, which edge-triggered commands such as M72 depend on.
  - It also gives a motion command time to drop `controller_ready`.
  - At terminal count:
    - if address = 2^ADDR_W−1: → DONE, `done`=1, `error`=1 (overrun, no M2 found). The address never wraps.
    - else: address+1 → FETCH.
- **DONE**: `done` and `error` hold. → FETCH on `start`, with the same clears as from IDLE.
- **block** high: state, address, outputs and the HOLDOFF counter are all frozen. `mem_rd` is forced to 0, and if FETCH is frozen, the read is reissued when `block` falls.
- **reset mid-operation**: aborts immediately. Any strobe in progress is cut.
- `cmd`/`x_value_in`/`y_value_in` stay stable from WAIT_RD exit until the next WAIT_RD.

## Timing

- Reset values: `mem_addr`=0, `mem_rd`=0, `cmd`=0, `x_value_in`=0, `y_value_in`=0, `memory_ready`=0, `busy`=0, `done`=0, `error`=0. State after reset is IDLE.
- All outputs are registered.
- Latency from `start` sampled to first strobe, with `controller_ready`=1: 4 cycles.
  - cycle 1: FETCH
  - cycle 2: WAIT_RD
  - cycle 3: ISSUE, strobe asserted at the next edge
- Steady-state throughput with the consumer always ready: one command per HOLDOFF_CYC+3 cycles.
- `start` is ignored while `busy`=1.
- `controller_ready` and `block` changing in the same cycle: `block` wins.

## Structure

- Package `scara_cmd_pkg` holds:
  - `cmd_code_t` enum in the order above
  - `CMD_W`=4, `COORD_W`=14, `CMD_WORD_W`=32
  - field LSB constants: `CMD_LSB`=28, `X_LSB`=14, `Y_LSB`=0
- The consumer interface is to import the same package.
- One natural sub-module: `cmd_word_unpack`. It is combinational and does field slicing plus the illegal-code and M2 flags. It is instantiated once in WAIT_RD.
- The FSM, address counter and holdoff counter live in the top module.

## Test plan

1. **Basic program.** Memory = {G20, G01 x=100 y=200, M2}, `controller_ready`=1, `start`.
   - Expect exactly 2 one-cycle strobes, carrying (2,0,0) and (1,100,200).
   - Expect `done`=1, `error`=0, and first strobe 4 cycles after `start`.
2. **Back-pressure.** Hold `controller_ready`=0 for 20 cycles in ISSUE.
   - No strobe during those cycles.
   - Strobe on the first cycle with `controller_ready`=1.
   - Fields are unchanged throughout.
3. **Block.** Assert `block` for 10 cycles, once during HOLDOFF and once during FETCH.
   - Counter and state freeze.
   - `mem_rd`=0 throughout.
   - The read is reissued after release and the command sequence is intact.
4. **Edge spacing.** Three consecutive M72 commands.
   - Three strobes, each separated by ≥HOLDOFF_CYC low cycles.
5. **Errors.**
   - Word with code 12: `done`=1, `error`=1, no strobe.
   - With ADDR_W=3 and no M2: 8 strobes, then `error`=1 with `mem_addr`=7.
6. **Reset and restart.**
   - `reset_n`=0 while `memory_ready`=1: next cycle all outputs are at reset values.
   - `start` from DONE reruns the program from address 0 with `done`/`error` cleared.
